fpu_add_scheduler: RTL and testbench
====================================

FPU_ADD_SCHEDULER -- requirements
Module: fpu_add_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum number of WAIT cycles before a timeout abort; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 2: per-requester operation valid; bit N belongs to requester N.
REQ-005 SHALL have port req_ready, output, 2: per-requester accept, one-hot or zero.
REQ-006 SHALL have port req_a, input, 64: packed {a1,a0}, IEEE-754 single operands.
REQ-007 SHALL have port req_b, input, 64: packed {b1,b0}.
REQ-008 SHALL have port req_sub, input, 2: per-requester subtract select.
REQ-009 SHALL have port req_rm, input, 4: packed {rm1,rm0}, 2-bit round modes.
REQ-010 SHALL have ports dp_start (out, 1), dp_a (out, 32), dp_b (out, 32), dp_sub (out, 1) and dp_rm (out, 2): command to the shared add/sub datapath.
REQ-011 SHALL have ports dp_done (in, 1), dp_result (in, 32), dp_ovf (in, 1) and dp_inexact (in, 1): datapath completion and result.
REQ-012 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_id (out, 1), rsp_result (out, 32) and rsp_flags (out, 2, {overflow, inexact}): response channel.
REQ-013 SHALL have ports busy (out, 1), high whenever the state is not IDLE, and timeout_err (out, 1), sticky timeout indication.

Function
REQ-014 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with no other transitions except reset.
REQ-015 In IDLE with any req_valid set, the block SHALL assert req_ready for exactly one granted requester, capture that requester's a, b, sub, rm and id into registers, and enter ISSUE.
REQ-016 Arbitration SHALL be round-robin: when both requesters are valid, grant goes to the one not granted last; the last-grant pointer resets to 1 so requester 0 wins the first contention.
REQ-017 req_ready SHALL be 0 in every state other than IDLE, and 0 in IDLE when req_valid is 0.
REQ-018 In ISSUE, dp_start SHALL be a single-cycle pulse, and the state SHALL advance to WAIT unconditionally.
REQ-019 dp_a, dp_b, dp_sub and dp_rm SHALL be driven from the captured registers and held stable from ISSUE through WAIT.
REQ-020 dp_done SHALL be sampled only in WAIT; when asserted, dp_result, dp_ovf and dp_inexact are registered into the rsp_* outputs and the state enters RESP; dp_done in any other state is ignored.
REQ-021 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL stay stable until rsp_ready is sampled 1, after which the state returns to IDLE.
REQ-022 Minimum latency SHALL be: accept at cycle T, dp_start at T+1, earliest dp_done at T+2, rsp_valid at T+3; peak throughput is one operation per 4 cycles.
REQ-023 A new request SHALL never be accepted in the same cycle as a response handshake.

Reset
REQ-024 On rst, the block SHALL set the state to IDLE, clear all captured registers, set the last-grant pointer to 1, clear the timeout counter and timeout_err, and drive req_ready=0, dp_start=0, dp_*=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0 and busy=0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation without a response; a dp_done arriving after reset falls in IDLE and is ignored.

Configuration
REQ-026 With FPU_SCHED_TIMEOUT_EN defined, the block SHALL include an 8-bit WAIT-cycle counter.
REQ-026a When that counter reaches TIMEOUT_CYCLES with no dp_done, the block SHALL enter RESP with rsp_result=0x7FC00000 and rsp_flags=2'b00, and SHALL set timeout_err sticky until reset.
REQ-027 Without FPU_SCHED_TIMEOUT_EN, the block SHALL wait in WAIT indefinitely, SHALL contain no counter, and SHALL tie timeout_err to 0; the port list is identical in both builds.

Structure
REQ-028 Package fpu_sched_pkg SHALL hold the state enum, FP_W=32, RM_W=2, NUM_REQ=2 and the constant QNAN=32'h7FC00000.
REQ-029 The grant logic SHALL be a sub-module rr_arbiter_2 (inputs req[1:0], last pointer, advance; output one-hot grant); all other logic stays in fpu_add_scheduler.

Verification
REQ-030 Scenario: single request from requester 0 (a=0x3F800000, b=0x40000000, sub=0) with dp_done returned 1 cycle after dp_start carrying 0x40400000 -> rsp_valid at T+3, rsp_id=0, rsp_result=0x40400000, rsp_flags=00.
REQ-031 Scenario: both requesters valid continuously for 4 operations -> grant order 0,1,0,1 and req_ready never 2'b11.
REQ-032 Scenario: rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable throughout, req_ready=0, no second dp_start.
REQ-033 Scenario: macro defined, TIMEOUT_CYCLES=4, dp_done never asserted -> RESP after 4 WAIT cycles with rsp_result=0x7FC00000, timeout_err=1 until rst.
REQ-034 Scenario: rst pulsed during WAIT, then dp_done pulsed -> outputs return to reset values, no rsp_valid, and the next contention is granted to requester 0.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg
//   Shared constants and types for the FP add/sub request scheduler.
//   FP_W    : IEEE-754 single-precision operand/result width
//   RM_W    : rounding-mode field width
//   NUM_REQ : number of requesters sharing the datapath
//   QNAN    : canonical quiet NaN returned when an operation times out
//   state_t : scheduler FSM states
package fpu_sched_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned RM_W    = 2;
    localparam int unsigned NUM_REQ = 2;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
//   Two-way round-robin grant logic (purely combinational).
//   req     : per-requester request bits
//   last    : index of the requester granted most recently
//   advance : grant is only produced while this is high
//   grant   : one-hot grant, or zero when nothing is granted
module rr_arbiter_2
    import fpu_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (advance) begin
            if (req == 2'b11) begin
                // Contention: favour whichever requester did not win last time.
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/fpu_add_scheduler.sv
// fpu_add_scheduler
//   Arbitrates two requesters onto one shared FP add/sub datapath and returns
//   each result on a single response channel. One operation in flight at a time:
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
//   Optional build macro FPU_SCHED_TIMEOUT_EN: adds an 8-bit WAIT-cycle counter;
//   after TIMEOUT_CYCLES WAIT cycles without dp_done the operation completes with
//   a quiet NaN result, zero flags, and timeout_err sets until reset. Without the
//   macro the block waits indefinitely and timeout_err is tied low.
//
//   Ports
//     clk, rst            : clock, asynchronous active-high reset
//     req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//     req_a, req_b        : packed {x1,x0} single-precision operands
//     req_sub, req_rm     : per-requester subtract select / packed round modes
//     dp_start, dp_a, dp_b, dp_sub, dp_rm : command to the shared datapath
//     dp_done, dp_result, dp_ovf, dp_inexact : datapath completion
//     rsp_valid/rsp_ready, rsp_id, rsp_result, rsp_flags {ovf,inexact} : response
//     busy                : high whenever not IDLE
//     timeout_err         : sticky timeout indication
module fpu_add_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    input  logic [NUM_REQ*RM_W-1:0] req_rm,
    output logic                    dp_start,
    output logic [FP_W-1:0]         dp_a,
    output logic [FP_W-1:0]         dp_b,
    output logic                    dp_sub,
    output logic [RM_W-1:0]         dp_rm,
    input  logic                    dp_done,
    input  logic [FP_W-1:0]         dp_result,
    input  logic                    dp_ovf,
    input  logic                    dp_inexact,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [FP_W-1:0]         rsp_result,
    output logic [1:0]              rsp_flags,
    output logic                    busy,
    output logic                    timeout_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
        $error("fpu_add_scheduler: TIMEOUT_CYCLES must be within 2..255");
    end

    state_t                  state;
    logic                    last_ptr;
    logic [NUM_REQ-1:0]      grant;
    logic                    cap_id;

    // Reset is gated in so req_ready is low while rst is held.
    rr_arbiter_2 u_arb (
        .req     (req_valid),
        .last    (last_ptr),
        .advance ((state == ST_IDLE) && !rst),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign dp_start  = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       wait_expired;

    // True on the final permitted WAIT cycle when dp_done has not arrived.
    assign wait_expired = (state == ST_WAIT) && !dp_done && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_WAIT && !dp_done) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (wait_expired) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic wait_expired;

    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_ptr   <= 1'b1;
            cap_id     <= 1'b0;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_sub     <= 1'b0;
            dp_rm      <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        cap_id   <= grant[1];
                        last_ptr <= grant[1];
                        dp_a     <= grant[1] ? req_a[2*FP_W-1:FP_W] : req_a[FP_W-1:0];
                        dp_b     <= grant[1] ? req_b[2*FP_W-1:FP_W] : req_b[FP_W-1:0];
                        dp_sub   <= grant[1] ? req_sub[1] : req_sub[0];
                        dp_rm    <= grant[1] ? req_rm[2*RM_W-1:RM_W] : req_rm[RM_W-1:0];
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dp_done) begin
                        rsp_id     <= cap_id;
                        rsp_result <= dp_result;
                        rsp_flags  <= {dp_ovf, dp_inexact};
                        state      <= ST_RESP;
                    end else if (wait_expired) begin
                        rsp_id     <= cap_id;
                        rsp_result <= QNAN;
                        rsp_flags  <= 2'b00;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// tb_fpu_add_scheduler
//   Self-checking bench for fpu_add_scheduler. A transaction-level model
//   (busy flag, cycles since accept, pending response) predicts every output on
//   every falling edge; directed scenarios add literal expectations, followed by
//   a randomized phase with random datapath completions and random resets.
//   Define FPU_SCHED_TIMEOUT_EN for both bench and RTL to cover the timeout build.
module tb_fpu_add_scheduler;

    localparam int unsigned TO = 4;
    localparam logic [31:0] QNAN_EXP = 32'h7FC0_0000;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_sub;
    logic [3:0]  req_rm;
    logic        dp_start;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic        dp_sub;
    logic [1:0]  dp_rm;
    logic        dp_done;
    logic [31:0] dp_result;
    logic        dp_ovf;
    logic        dp_inexact;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_flags;
    logic        busy;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_add_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sub     (req_sub),
        .req_rm      (req_rm),
        .dp_start    (dp_start),
        .dp_a        (dp_a),
        .dp_b        (dp_b),
        .dp_sub      (dp_sub),
        .dp_rm       (dp_rm),
        .dp_done     (dp_done),
        .dp_result   (dp_result),
        .dp_ovf      (dp_ovf),
        .dp_inexact  (dp_inexact),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy  = 0;
    bit          m_rsp   = 0;
    logic        m_last  = 1'b1;
    int          m_age   = 0;
    logic [31:0] m_a     = '0;
    logic [31:0] m_b     = '0;
    logic        m_sub   = 1'b0;
    logic [1:0]  m_rm    = '0;
    logic        m_id    = 1'b0;
    logic [31:0] m_res   = '0;
    logic [1:0]  m_flags = '0;
    logic        m_rid   = 1'b0;
    logic        m_terr  = 1'b0;

    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(negedge clk) begin : model_cmp
        logic [1:0] exp_ready;
        if (rst) begin
            m_busy = 0; m_rsp = 0; m_last = 1'b1; m_age = 0;
            m_a = '0; m_b = '0; m_sub = 1'b0; m_rm = '0; m_id = 1'b0;
            m_res = '0; m_flags = '0; m_rid = 1'b0; m_terr = 1'b0;
        end
        exp_ready = (!rst && !m_busy) ? rr_pick(req_valid, m_last) : 2'b00;

        chk("req_ready",   req_ready,   exp_ready);
        chk("dp_start",    dp_start,    m_busy && !m_rsp && m_age == 1);
        chk("dp_a",        dp_a,        m_a);
        chk("dp_b",        dp_b,        m_b);
        chk("dp_sub",      dp_sub,      m_sub);
        chk("dp_rm",       dp_rm,       m_rm);
        chk("rsp_valid",   rsp_valid,   m_rsp);
        chk("rsp_id",      rsp_id,      m_rid);
        chk("rsp_result",  rsp_result,  m_res);
        chk("rsp_flags",   rsp_flags,   m_flags);
        chk("busy",        busy,        m_busy);
        chk("timeout_err", timeout_err, m_terr);

        // Advance the model by the clock edge that follows.
        if (!rst) begin
            if (!m_busy) begin
                if (exp_ready != 2'b00) begin
                    m_id   = exp_ready[1];
                    m_last = m_id;
                    m_a    = m_id ? req_a[63:32] : req_a[31:0];
                    m_b    = m_id ? req_b[63:32] : req_b[31:0];
                    m_sub  = req_sub[m_id];
                    m_rm   = m_id ? req_rm[3:2] : req_rm[1:0];
                    m_busy = 1;
                    m_age  = 1;
                end
            end else if (m_rsp) begin
                if (rsp_ready) begin
                    m_busy = 0;
                    m_rsp  = 0;
                end
            end else begin
                // Completion is only honoured from the second cycle after accept on.
                if (m_age >= 2 && dp_done) begin
                    m_rsp   = 1;
                    m_res   = dp_result;
                    m_flags = {dp_ovf, dp_inexact};
                    m_rid   = m_id;
                end
`ifdef FPU_SCHED_TIMEOUT_EN
                else if (m_age >= 2 && (m_age - 1) == int'(TO)) begin
                    m_rsp   = 1;
                    m_res   = QNAN_EXP;
                    m_flags = 2'b00;
                    m_rid   = m_id;
                    m_terr  = 1'b1;
                end
`endif
                m_age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int got[$];

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_a = '0; req_b = '0; req_sub = '0; req_rm = '0;
        dp_done = 1'b0; dp_result = '0; dp_ovf = 1'b0; dp_inexact = 1'b0; rsp_ready = 1'b0;

        // Reset values, with requests present during reset.
        @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_dp_start", dp_start, 1'b0);
        tick();
        rst = 1'b0; req_valid = 2'b00;
        tick();

        // Single request from requester 0, dp_done one cycle after dp_start.
        req_valid = 2'b01; req_a = {32'h0, 32'h3F80_0000}; req_b = {32'h0, 32'h4000_0000};
        req_sub = 2'b00; req_rm = 4'b0000;
        @(negedge clk);
        chk("s1_accept", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        chk("s1_start", dp_start, 1'b1);
        chk("s1_dp_a", dp_a, 32'h3F80_0000);
        chk("s1_dp_b", dp_b, 32'h4000_0000);
        tick(); dp_done = 1'b1; dp_result = 32'h4040_0000;
        @(negedge clk);
        chk("s1_no_rsp_yet", rsp_valid, 1'b0);
        tick(); dp_done = 1'b0; dp_result = 32'hDEAD_BEEF; req_valid = 2'b11;
        @(negedge clk);
        chk("s1_rsp_valid", rsp_valid, 1'b1);
        chk("s1_rsp_id", rsp_id, 1'b0);
        chk("s1_rsp_result", rsp_result, 32'h4040_0000);
        chk("s1_rsp_flags", rsp_flags, 2'b00);

        // Stall in RESP with rsp_ready low; stray dp_done must be ignored.
        for (int k = 0; k < 5; k++) begin
            tick(); dp_done = 1'b1; dp_ovf = 1'b1;
            @(negedge clk);
            chk("s2_rsp_hold", rsp_valid, 1'b1);
            chk("s2_result_hold", rsp_result, 32'h4040_0000);
            chk("s2_flags_hold", rsp_flags, 2'b00);
            chk("s2_no_ready", req_ready, 2'b00);
            chk("s2_no_start", dp_start, 1'b0);
        end
        tick(); rsp_ready = 1'b1; dp_done = 1'b0; dp_ovf = 1'b0;
        @(negedge clk);
        chk("s2_handshake_no_accept", req_ready, 2'b00);
        tick(); rsp_ready = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        chk("s2_back_idle", busy, 1'b0);

        // Continuous contention: grants alternate starting with requester 0.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req_valid = 2'b11; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
        dp_done = 1'b1; dp_result = $urandom; rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got.push_back(int'(req_ready[1]));
            tick();
        end
        chk("s3_grant_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("s3_grant_order", (i < got.size()) ? got[i] : 99, i % 2);
        req_valid = 2'b00;
        repeat (6) tick();
        dp_done = 1'b0; rsp_ready = 1'b0;
        tick();

        // Reset during WAIT abandons the operation and restores the pointer.
        req_valid = 2'b01; req_a = {32'h0, 32'h1234_5678};
        tick(); req_valid = 2'b00;
        tick();
        @(negedge clk);
        chk("s4_in_wait", busy, 1'b1);
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("s4_rst_busy", busy, 1'b0);
        chk("s4_rst_dp_a", dp_a, 32'h0);
        chk("s4_rst_rsp", rsp_valid, 1'b0);
        tick(); rst = 1'b0; dp_done = 1'b1; dp_result = 32'hCAFE_F00D;
        @(negedge clk);
        chk("s4_late_done_rsp", rsp_valid, 1'b0);
        chk("s4_late_done_busy", busy, 1'b0);
        tick(); dp_done = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        chk("s4_first_contention", req_ready, 2'b01);
        tick(); req_valid = 2'b00; dp_done = 1'b1; rsp_ready = 1'b1;
        repeat (5) tick();
        dp_done = 1'b0; rsp_ready = 1'b0;

`ifdef FPU_SCHED_TIMEOUT_EN
        // No dp_done: quiet NaN after TO WAIT cycles, sticky error until reset.
        req_valid = 2'b01;
        @(negedge clk);
        chk("s5_accept", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        for (int k = 0; k < int'(TO); k++) begin
            tick();
            @(negedge clk);
            chk("s5_waiting", rsp_valid, 1'b0);
        end
        tick();
        @(negedge clk);
        chk("s5_rsp_valid", rsp_valid, 1'b1);
        chk("s5_qnan", rsp_result, QNAN_EXP);
        chk("s5_flags", rsp_flags, 2'b00);
        chk("s5_terr", timeout_err, 1'b1);
        tick(); rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        @(negedge clk);
        chk("s5_terr_sticky", timeout_err, 1'b1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("s5_terr_cleared", timeout_err, 1'b0);
`endif

        // Randomized traffic with occasional resets.
        repeat (1500) begin
            tick();
            rst        = ($urandom_range(0, 199) == 0);
            req_valid  = 2'($urandom_range(0, 3));
            req_a      = {$urandom, $urandom};
            req_b      = {$urandom, $urandom};
            req_sub    = 2'($urandom_range(0, 3));
            req_rm     = 4'($urandom_range(0, 15));
            dp_done    = ($urandom_range(0, 2) == 0);
            dp_result  = $urandom;
            dp_ovf     = 1'($urandom_range(0, 1));
            dp_inexact = 1'($urandom_range(0, 1));
            rsp_ready  = 1'($urandom_range(0, 1));
        end
        tick();
        rst = 1'b0; req_valid = 2'b00; dp_done = 1'b0; rsp_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
